// File: rtl/march_bist_ctrl_pkg.sv
// Shared types for the March BIST controller: FSM states, op encoding and the
// per-algorithm element tables walked by the controller.
package march_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_W0,
    OP_R0,
    OP_W1,
    OP_R1
  } op_e;

  // One March element: address direction, 1 or 2 ops, ops in issue order.
  typedef struct packed {
    logic       dir_down;
    logic [1:0] n_ops;
    op_e        op0;
    op_e        op1;
  } elem_t;

  localparam int EL_IDX_W   = 3;
  localparam int MATS_LEN   = 3;
  localparam int MARCHC_LEN = 6;

  localparam logic [EL_IDX_W-1:0] MATS_LAST   = 3'(MATS_LEN - 1);
  localparam logic [EL_IDX_W-1:0] MARCHC_LAST = 3'(MARCHC_LEN - 1);

  localparam elem_t MATS_TAB [MATS_LEN] = '{
    '{1'b0, 2'd1, OP_W0, OP_W0},
    '{1'b0, 2'd2, OP_R0, OP_W1},
    '{1'b1, 2'd2, OP_R1, OP_W0}
  };

  localparam elem_t MARCHC_TAB [MARCHC_LEN] = '{
    '{1'b0, 2'd1, OP_W0, OP_W0},
    '{1'b0, 2'd2, OP_R0, OP_W1},
    '{1'b0, 2'd2, OP_R1, OP_W0},
    '{1'b1, 2'd2, OP_R0, OP_W1},
    '{1'b1, 2'd2, OP_R1, OP_W0},
    '{1'b0, 2'd1, OP_R0, OP_R0}
  };

  function automatic elem_t elem_lookup(input logic mode, input logic [EL_IDX_W-1:0] idx);
    elem_t e;
    e = '0;
    if (mode) begin
      if (idx <= MARCHC_LAST) e = MARCHC_TAB[idx];
    end else begin
      if (idx <= MATS_LAST) e = MATS_TAB[idx[1:0]];
    end
    return e;
  endfunction

  function automatic logic [EL_IDX_W-1:0] last_elem(input logic mode);
    return mode ? MARCHC_LAST : MATS_LAST;
  endfunction

  function automatic logic op_is_read(input op_e op);
    return (op == OP_R0) || (op == OP_R1);
  endfunction

  function automatic logic op_is_one(input op_e op);
    return (op == OP_W1) || (op == OP_R1);
  endfunction

endpackage

// File: rtl/march_bist_ctrl_if.sv
// Single-port synchronous RAM bus between the BIST controller (master) and
// the memory under test (slave); read data returns one cycle after mem_re.
interface march_bist_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/march_bist_ctrl_addr_gen.sv
// Up/down address counter for one March element: load to 0 (up) or N-1 (down),
// step on enable, flag the element's last address.
module bist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_load_down,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_tc
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_down;

  // Direction is captured at load so it stays fixed for the whole element.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_addr <= i_load_down ? '1 : '0;
      r_down <= i_load_down;
    end else if (i_en) begin
      r_addr <= r_down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
    end
  end

  assign o_addr = r_addr;
  assign o_tc   = r_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/march_bist_ctrl.sv
// March-test BIST controller (MATS+ / March C-): walks the element tables over
// the RAM, compares reads one cycle later and records sticky fail results.
module march_bist_ctrl
  import march_bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int FCNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  march_bist_ctrl_if.master  mem,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [FCNT_W-1:0]  fail_cnt
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_mode;
  logic [EL_IDX_W-1:0] r_el;
  logic                r_op;

  elem_t               w_elem;
  elem_t               w_elem_nxt;
  op_e                 w_op;
  logic                w_last_op;
  logic                w_last_el;
  logic                w_accept;
  logic                w_ld;
  logic                w_ld_down;
  logic                w_en;
  logic                w_step_op;
  logic                w_step_el;
  logic                w_we;
  logic                w_re;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_tc;

  logic                r_vld_p1;
  logic [DATA_W-1:0]   r_exp_p1;
  logic [ADDR_W-1:0]   r_addr_p1;
  logic                w_miss;

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    return (v == '1) ? v : (v + FCNT_W'(1));
  endfunction

  bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_ld),
    .i_load_down (w_ld_down),
    .i_en        (w_en),
    .o_addr      (w_addr),
    .o_tc        (w_tc)
  );

  assign w_elem     = elem_lookup(r_mode, r_el);
  assign w_elem_nxt = elem_lookup(r_mode, r_el + EL_IDX_W'(1));
  assign w_op       = r_op ? w_elem.op1 : w_elem.op0;
  assign w_last_op  = (w_elem.n_ops == 2'd1) || r_op;
  assign w_last_el  = (r_el == last_elem(r_mode));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ld        = 1'b0;
    w_ld_down   = 1'b0;
    w_en        = 1'b0;
    w_step_op   = 1'b0;
    w_step_el   = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_ld        = 1'b1;
          w_ld_down   = elem_lookup(mode, '0).dir_down;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_re = op_is_read(w_op);
        w_we = !op_is_read(w_op);
        // Finish every op at this address, then step; the terminal address
        // hands over straight to the next element's start address.
        if (!w_last_op) begin
          w_step_op = 1'b1;
        end else if (!w_tc) begin
          w_en = 1'b1;
        end else if (w_last_el) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_step_el = 1'b1;
          w_ld      = 1'b1;
          w_ld_down = w_elem_nxt.dir_down;
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_el   <= '0;
      r_op   <= 1'b0;
    end else if (w_accept) begin
      r_mode <= mode;
      r_el   <= '0;
      r_op   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_op <= w_step_op;
      if (w_step_el) r_el <= r_el + EL_IDX_W'(1);
    end
  end

  assign mem.mem_addr  = w_addr;
  assign mem.mem_we    = w_we;
  assign mem.mem_re    = w_re;
  assign mem.mem_wdata = {DATA_W{w_we & op_is_one(w_op)}};

  // p0 -> p1: a read issued now is checked against returned data next cycle.
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_re;
  end

  always_ff @(posedge clk) begin
    r_exp_p1  <= {DATA_W{op_is_one(w_op)}};
    r_addr_p1 <= w_addr;
  end

  assign w_miss = r_vld_p1 && (mem.mem_rdata != r_exp_p1);

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_cnt  <= '0;
    end else if (w_miss) begin
      fail     <= 1'b1;
      fail_cnt <= sat_inc(fail_cnt);
      if (!fail) fail_addr <= r_addr_p1;
    end
  end

  assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

endmodule
